// File: rtl/updown_counter_ctrl.sv
// rtl/updown_counter_ctrl.sv - windowed up/down counter with programmable step, wrap or saturate
// Count window is [min_value, max_value]; all step arithmetic is one bit wider than the count.
module updown_counter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  down,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      min_value,
  input  logic [WIDTH-1:0]      max_value,
  input  logic                  wrap_mode,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      count,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  wrap_pulse,
  output logic                  sat_sticky,
  output logic                  cfg_err
);

  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             cfg_q, cfg_d;

  logic [EW-1:0]    step_x, cnt_x, min_x, max_x, sum_x, floor_x;
  logic [WIDTH-1:0] load_clamped;
  logic             step_active, sat_set;

  assign step_x  = {{(EW-STEP_WIDTH){1'b0}}, step};
  assign cnt_x   = {1'b0, count_q};
  assign min_x   = {1'b0, min_value};
  assign max_x   = {1'b0, max_value};
  assign sum_x   = cnt_x + step_x;
  assign floor_x = min_x + step_x;

  assign cfg_d       = (min_value > max_value);
  assign step_active = enable & (up ^ down) & (step != '0);

  assign load_clamped = (load_value < min_value) ? min_value :
                        (load_value > max_value) ? max_value : load_value;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_set = 1'b0;
    if (cfg_d) begin
      count_d = count_q;
    end else if (load) begin
      count_d = load_clamped;
    end else if (step_active) begin
      // An out-of-window count is pulled back to the nearest bound silently.
      if (count_q > max_value) begin
        count_d = max_value;
      end else if (count_q < min_value) begin
        count_d = min_value;
      end else if (up) begin
        if (sum_x <= max_x) begin
          count_d = sum_x[WIDTH-1:0];
        end else if (wrap_mode) begin
          count_d = min_value;
          wrap_d  = 1'b1;
        end else begin
          count_d = max_value;
          sat_set = 1'b1;
        end
      end else begin
        if (cnt_x >= floor_x) begin
          count_d = count_q - step_x[WIDTH-1:0];
        end else if (wrap_mode) begin
          count_d = max_value;
          wrap_d  = 1'b1;
        end else begin
          count_d = min_value;
          sat_set = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (!cfg_d && load) begin
      sat_d = 1'b0;
    end else if (sat_set) begin
      sat_d = 1'b1;
    end else if (clear_flags) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      cfg_q   <= cfg_d;
    end
  end

  assign count      = count_q;
  assign at_max     = (count_q == max_value);
  assign at_min     = (count_q == min_value);
  assign wrap_pulse = wrap_q;
  assign sat_sticky = sat_q;
  assign cfg_err    = cfg_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// tb/tb_updown_counter_ctrl.sv - self-checking bench for updown_counter_ctrl (8-bit and 4-bit instances)
module tb_updown_counter_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       a_load = 0, a_en = 0, a_up = 0, a_dn = 0, a_wm = 0, a_clr = 0;
  logic [7:0] a_lv = 0, a_min = 0, a_max = 0;
  logic [3:0] a_st = 0;
  logic [7:0] a_count;
  logic       a_at_max, a_at_min, a_wrap, a_sat, a_cfg;

  // 4-bit instance with full-width step
  logic       b_load = 0, b_en = 0, b_up = 0, b_dn = 0, b_wm = 0, b_clr = 0;
  logic [3:0] b_lv = 0, b_min = 0, b_max = 0;
  logic [3:0] b_st = 0;
  logic [3:0] b_count;
  logic       b_at_max, b_at_min, b_wrap, b_sat, b_cfg;

  updown_counter_ctrl #(.WIDTH(8), .STEP_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .load(a_load), .load_value(a_lv), .enable(a_en),
    .up(a_up), .down(a_dn), .step(a_st), .min_value(a_min), .max_value(a_max),
    .wrap_mode(a_wm), .clear_flags(a_clr), .count(a_count), .at_max(a_at_max),
    .at_min(a_at_min), .wrap_pulse(a_wrap), .sat_sticky(a_sat), .cfg_err(a_cfg)
  );

  updown_counter_ctrl #(.WIDTH(4), .STEP_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .load(b_load), .load_value(b_lv), .enable(b_en),
    .up(b_up), .down(b_dn), .step(b_st), .min_value(b_min), .max_value(b_max),
    .wrap_mode(b_wm), .clear_flags(b_clr), .count(b_count), .at_max(b_at_max),
    .at_min(b_at_min), .wrap_pulse(b_wrap), .sat_sticky(b_sat), .cfg_err(b_cfg)
  );

  int checks = 0;
  int failures = 0;

  int ma_c = 0, ma_w = 0, ma_s = 0, ma_e = 0;
  int mb_c = 0, mb_w = 0, mb_s = 0, mb_e = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic (no width limits).
  task automatic model_step(input int mn, input int mx, input int ld, input int lv,
                            input int en, input int u, input int d, input int st,
                            input int wm, input int clr,
                            inout int c, inout int w, inout int s, inout int e);
    int set;
    set = 0;
    w   = 0;
    e   = (mn > mx);
    if (mn > mx) begin
      if (clr != 0) s = 0;
    end else if (ld != 0) begin
      c = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
      s = 0;
    end else begin
      if (en != 0 && u != d && st != 0) begin
        if (c > mx) c = mx;
        else if (c < mn) c = mn;
        else if (u != 0) begin
          if (c + st <= mx) c = c + st;
          else if (wm != 0) begin c = mn; w = 1; end
          else begin c = mx; set = 1; end
        end else begin
          if (c - st >= mn) c = c - st;
          else if (wm != 0) begin c = mx; w = 1; end
          else begin c = mn; set = 1; end
        end
      end
      if (set != 0) s = 1;
      else if (clr != 0) s = 0;
    end
  endtask

  task automatic check_all();
    chk("a_count",  a_count,  ma_c);
    chk("a_wrap",   a_wrap,   ma_w);
    chk("a_sat",    a_sat,    ma_s);
    chk("a_cfg",    a_cfg,    ma_e);
    chk("a_at_max", a_at_max, (ma_c == int'(a_max)));
    chk("a_at_min", a_at_min, (ma_c == int'(a_min)));
    chk("b_count",  b_count,  mb_c);
    chk("b_wrap",   b_wrap,   mb_w);
    chk("b_sat",    b_sat,    mb_s);
    chk("b_cfg",    b_cfg,    mb_e);
    chk("b_at_max", b_at_max, (mb_c == int'(b_max)));
    chk("b_at_min", b_at_min, (mb_c == int'(b_min)));
  endtask

  task automatic tick();
    model_step(int'(a_min), int'(a_max), int'(a_load), int'(a_lv), int'(a_en), int'(a_up),
               int'(a_dn), int'(a_st), int'(a_wm), int'(a_clr), ma_c, ma_w, ma_s, ma_e);
    model_step(int'(b_min), int'(b_max), int'(b_load), int'(b_lv), int'(b_en), int'(b_up),
               int'(b_dn), int'(b_st), int'(b_wm), int'(b_clr), mb_c, mb_w, mb_s, mb_e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    ma_c = 0; ma_w = 0; ma_s = 0; ma_e = 0;
    mb_c = 0; mb_w = 0; mb_s = 0; mb_e = 0;
  endtask

  initial begin
    // Reset, basic up count
    a_min = 0; a_max = 255; a_st = 1; a_wm = 1;
    #2;
    chk("rst_count", a_count, 0);
    chk("rst_flags", {a_wrap, a_sat, a_cfg}, 0);
    chk("rst_at_min", a_at_min, 1);
    chk("rst_b_count", b_count, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    a_en = 1; a_up = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("up_seq", a_count, i);
      chk("up_at_min", a_at_min, 0);
    end

    // Asynchronous reset mid-run
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", a_count, 0);
    chk("async_rst_at_min", a_at_min, 1);
    #1 reset = 1'b1;
    tick();
    chk("first_after_rst", a_count, 1);

    // Wrap up then down
    a_min = 10; a_max = 20; a_wm = 1; a_load = 1; a_lv = 18;
    tick();
    chk("wrap_load", a_count, 18);
    a_load = 0; a_st = 3;
    tick();
    chk("wrap_up_count", a_count, 10);
    chk("wrap_up_pulse", a_wrap, 1);
    a_up = 0; a_dn = 1; a_st = 1;
    tick();
    chk("wrap_dn_count", a_count, 20);
    chk("wrap_dn_pulse", a_wrap, 1);
    chk("wrap_dn_at_max", a_at_max, 1);
    a_en = 0;
    tick();
    chk("wrap_pulse_drop", a_wrap, 0);

    // Saturation and sticky clear
    a_wm = 0; a_load = 1; a_lv = 19;
    tick();
    a_load = 0; a_en = 1; a_up = 1; a_dn = 0; a_st = 4;
    tick();
    chk("sat_count1", a_count, 20);
    chk("sat_flag1", a_sat, 1);
    tick();
    chk("sat_count2", a_count, 20);
    chk("sat_flag2", a_sat, 1);
    a_en = 0; a_clr = 1;
    tick();
    chk("sat_cleared", a_sat, 0);
    a_en = 1;
    tick();
    chk("sat_set_beats_clear", a_sat, 1);
    a_clr = 0;

    // Priority and holds
    a_min = 0; a_load = 1; a_lv = 5;
    tick();
    chk("load_priority", a_count, 5);
    chk("load_clears_sat", a_sat, 0);
    a_load = 0; a_dn = 1;
    tick();
    chk("hold_both", a_count, 5);
    a_dn = 0; a_st = 0;
    tick();
    chk("hold_step0", a_count, 5);
    a_load = 1; a_lv = 50;
    tick();
    chk("load_clamp", a_count, 20);

    // Window change and configuration error
    a_lv = 15;
    tick();
    a_load = 0; a_max = 12; a_st = 1;
    tick();
    chk("window_pull", a_count, 12);
    chk("window_no_flags", {a_wrap, a_sat}, 0);
    a_min = 30; a_load = 1; a_lv = 5;
    tick();
    chk("cfg_err_set", a_cfg, 1);
    chk("cfg_freeze_load", a_count, 12);
    a_load = 0;
    tick();
    chk("cfg_freeze_count", a_count, 12);
    a_min = 0;
    tick();
    chk("cfg_err_clear", a_cfg, 0);

    // 4-bit width extremes
    a_en = 0;
    b_min = 0; b_max = 15; b_wm = 1; b_load = 1; b_lv = 14;
    tick();
    b_load = 0; b_en = 1; b_up = 1; b_st = 15;
    tick();
    chk("w4_wrap_count", b_count, 0);
    chk("w4_wrap_pulse", b_wrap, 1);
    b_up = 0; b_dn = 1; b_wm = 0;
    tick();
    chk("w4_sat_count", b_count, 0);
    chk("w4_sat_flag", b_sat, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a_load = ($urandom_range(0, 7) == 0);
      a_lv   = 8'($urandom_range(0, 255));
      a_en   = ($urandom_range(0, 5) != 0);
      a_up   = 1'($urandom_range(0, 1));
      a_dn   = 1'($urandom_range(0, 1));
      a_st   = 4'($urandom_range(0, 15));
      a_wm   = 1'($urandom_range(0, 1));
      a_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        a_min = 8'($urandom_range(0, 60));
        a_max = 8'($urandom_range(0, 80));
      end
      b_load = ($urandom_range(0, 7) == 0);
      b_lv   = 4'($urandom_range(0, 15));
      b_en   = 1'($urandom_range(0, 1));
      b_up   = 1'($urandom_range(0, 1));
      b_dn   = 1'($urandom_range(0, 1));
      b_st   = 4'($urandom_range(0, 15));
      b_wm   = 1'($urandom_range(0, 1));
      b_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        b_min = 4'($urandom_range(0, 8));
        b_max = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
